pomdp_belief_update: RTL and testbench

Parametrised, multi-cycle POMDP belief-update engine for the PBVI pipeline. It computes b'(j) ∝ O[a][j][o] · Σᵢ T[a][i][j] · b(i) over N states, A actions and Z observations in Q0.W fixed point. It shares one multiplier and one iterative divider across all states instead of unrolling combinationally. It sits between the observation front end and the decision block, using valid/ready handshakes on both sides.

---
 rtl/pomdp_belief_update_if.sv | 32 +++
 rtl/pomdp_belief_update.sv | 153 +++++++++++++++
 tb/tb_pomdp_belief_update.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pomdp_belief_update_if.sv
// Request/result bundle for the POMDP belief-update engine.
interface pomdp_belief_update_if #(
  parameter int N_STATES  = 4,
  parameter int N_ACTIONS = 3,
  parameter int N_OBS     = 2,
  parameter int W         = 16
);
  localparam int AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
  localparam int OW = (N_OBS > 1) ? $clog2(N_OBS) : 1;

  logic                                                in_valid;
  logic                                                in_ready;
  logic [N_ACTIONS-1:0][N_STATES-1:0][N_STATES-1:0][W-1:0] trans;
  logic [N_ACTIONS-1:0][N_STATES-1:0][N_OBS-1:0][W-1:0]    observe;
  logic [N_STATES-1:0][W-1:0]                          belief_in;
  logic [AW-1:0]                                       action;
  logic [OW-1:0]                                       observation;
  logic                                                out_valid;
  logic                                                out_ready;
  logic [N_STATES-1:0][W-1:0]                          belief_out;
  logic                                                degenerate;
  logic                                                busy;

  modport master (
    output in_valid, trans, observe, belief_in, action, observation, out_ready,
    input  in_ready, out_valid, belief_out, degenerate, busy
  );
  modport slave (
    input  in_valid, trans, observe, belief_in, action, observation, out_ready,
    output in_ready, out_valid, belief_out, degenerate, busy
  );
endinterface

// File: rtl/pomdp_belief_update.sv
// Multi-cycle belief update b'(j) ~ O[a][j][o] * sum_i T[a][i][j]*b(i), one shared
// multiplier for predict/correct and one restoring divider for normalisation.
module pomdp_belief_update #(
  parameter int N_STATES  = 4,
  parameter int N_ACTIONS = 3,
  parameter int N_OBS     = 2,
  parameter int W         = 16
) (
  input logic clk,
  input logic rst,
  pomdp_belief_update_if.slave bus
);
  localparam int SW   = $clog2(N_STATES);
  localparam int AW   = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
  localparam int OW   = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int ACCW = 2*W + SW;
  localparam int BW   = $clog2(W + 1);
  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

  typedef enum logic [2:0] {IDLE, PREDICT, CORRECT, DIVIDE, DONE} state_t;

  state_t state, state_n;

  logic [N_STATES-1:0][W-1:0]   b_r, t_r, bo_r;
  logic [N_STATES-1:0][2*W-1:0] o_r;
  logic [AW-1:0]                act_r, act_sel;
  logic [OW-1:0]                obs_r, obs_sel;
  logic [ACCW-1:0]              acc, total, acc_n, total_n;
  logic [W-1:0]                 den, den_c, t_new;
  logic [W-1:0]                 mul_a, mul_b;
  logic [2*W-1:0]               prod, o_cur;
  logic [W:0]                   rem, shifted, rem_nx, q_nx;
  logic [W-1:0]                 quo, dvd, q_sat;
  logic                         ovf, ovf_c, first, ge, last_b, degen, bad_req;
  logic [SW-1:0]                ci, cj;
  logic [BW-1:0]                cb;

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.belief_out = bo_r;
  assign bus.degenerate = degen;

  always_comb begin
    bad_req = (32'(bus.action) >= N_ACTIONS) || (32'(bus.observation) >= N_OBS);
    act_sel = (32'(act_r) < N_ACTIONS) ? act_r : '0;
    obs_sel = (32'(obs_r) < N_OBS) ? obs_r : '0;
    if (state == PREDICT) begin
      mul_a = bus.trans[act_sel][ci][cj];
      mul_b = b_r[ci];
    end else begin
      mul_a = bus.observe[act_sel][cj][obs_sel];
      mul_b = t_r[cj];
    end
    prod    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    acc_n   = acc + {{SW{1'b0}}, prod};
    total_n = total + {{SW{1'b0}}, prod};
    t_new   = (|acc_n[ACCW-1:2*W])   ? '1 : acc_n[2*W-1:W];
    den_c   = (|total_n[ACCW-1:2*W]) ? '1 : total_n[2*W-1:W];

    // First step of each element seeds the remainder with o[j]>>(W+1); a seed
    // already >= den means the true quotient needs more than W+1 bits.
    o_cur   = o_r[cj];
    first   = (cb == '0);
    last_b  = (cb == BW'(W));
    shifted = first ? {1'b0, o_cur[2*W-1:W+1], o_cur[W]} : {rem[W-1:0], dvd[W-1]};
    ovf_c   = first ? ({1'b0, o_cur[2*W-1:W+1]} >= den) : (ovf | rem[W]);
    ge      = (shifted >= {1'b0, den});
    rem_nx  = ge ? (shifted - {1'b0, den}) : shifted;
    q_nx    = {(first ? {W{1'b0}} : quo), ge};
    q_sat   = (ovf_c || q_nx[W]) ? '1 : q_nx[W-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = bad_req ? DONE : PREDICT;
      PREDICT: if (ci == LAST && cj == LAST) state_n = CORRECT;
      CORRECT: if (cj == LAST) state_n = (den_c == '0) ? DONE : DIVIDE;
      DIVIDE:  if (last_b && cj == LAST) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_r <= '0; t_r <= '0; bo_r <= '0; o_r <= '0;
      act_r <= '0; obs_r <= '0; acc <= '0; total <= '0; den <= '0;
      rem <= '0; quo <= '0; dvd <= '0; ovf <= 1'b0; degen <= 1'b0;
      ci <= '0; cj <= '0; cb <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          b_r   <= bus.belief_in;
          act_r <= bus.action;
          obs_r <= bus.observation;
          acc   <= '0;
          total <= '0;
          ci    <= '0;
          cj    <= '0;
          cb    <= '0;
          degen <= bad_req;
          if (bad_req) bo_r <= bus.belief_in;
        end
        PREDICT: begin
          if (ci == LAST) begin
            t_r[cj] <= t_new;
            acc     <= '0;
            ci      <= '0;
            cj      <= (cj == LAST) ? '0 : cj + 1'b1;
          end else begin
            acc <= acc_n;
            ci  <= ci + 1'b1;
          end
        end
        CORRECT: begin
          o_r[cj] <= prod;
          total   <= total_n;
          if (cj == LAST) begin
            cj  <= '0;
            den <= den_c;
            if (den_c == '0) begin
              degen <= 1'b1;
              bo_r  <= b_r;
            end
          end else begin
            cj <= cj + 1'b1;
          end
        end
        DIVIDE: begin
          rem <= rem_nx;
          quo <= q_nx[W-1:0];
          ovf <= ovf_c;
          dvd <= first ? o_cur[W-1:0] : {dvd[W-2:0], 1'b0};
          if (last_b) begin
            bo_r[cj] <= q_sat;
            cb       <= '0;
            cj       <= (cj == LAST) ? '0 : cj + 1'b1;
          end else begin
            cb <= cb + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pomdp_belief_update.sv
// Scoreboard bench for pomdp_belief_update at N=2, A=3, Z=2, W=16.
module tb_pomdp_belief_update;
  localparam int N = 2, A = 3, Z = 2, W = 16;
  localparam int LAT_NOM = N*N + N + N*(W+1) + 1;
  localparam int LAT_DEN = N*N + N + 1;
  localparam int LAT_BAD = 1;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t b;
    logic deg;
    int   acc;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_ov = 1'b0;
  int   rise = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pomdp_belief_update_if #(.N_STATES(N), .N_ACTIONS(A), .N_OBS(Z), .W(W)) bus ();
  pomdp_belief_update #(.N_STATES(N), .N_ACTIONS(A), .N_OBS(Z), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [W-1:0] w0, input logic [W-1:0] w1);
    vec_t v;
    v[0] = w0;
    v[1] = w1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid && !prev_ov) begin
      rise = cyc;
      chk("result_expected", 64'(sb.size() != 0), 64'd1);
    end
    prev_ov = bus.out_valid;
    if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("belief_out", 64'(bus.belief_out), 64'(mon_e.b));
      chk("degenerate", 64'(bus.degenerate), 64'(mon_e.deg));
      chk("latency", 64'(rise - mon_e.acc), 64'(mon_e.lat));
    end
  end

  task automatic drive_req(input vec_t b, input int a, input int o,
                           input vec_t eb, input logic ed, input int el);
    exp_t e;
    int   n;
    bit   got;
    @(posedge clk); #1;
    bus.belief_in   = b;
    bus.action      = 2'(a);
    bus.observation = 1'(o);
    bus.in_valid    = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
      n++;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    e.b = eb; e.deg = ed; e.acc = cyc; e.lat = el;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic set_tables();
    bus.trans   = '0;
    bus.observe = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        bus.trans[0][i][j] = 16'h8000;
        bus.trans[1][i][j] = 16'h8000;
      end
    bus.observe[0][0][0] = 16'hC000;
    bus.observe[0][1][0] = 16'h4000;
    bus.observe[1][0][1] = 16'h2000;
    bus.observe[1][1][1] = 16'h6000;
    bus.trans[2][0][0]   = 16'hFFFF;
    for (int j = 0; j < N; j++)
      for (int o = 0; o < Z; o++) bus.observe[2][j][o] = 16'hFFFF;
  endtask

  initial begin
    int   n;
    vec_t nom;
    nom = mkv(16'hC000, 16'h4000);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.belief_in = '0; bus.action = '0; bus.observation = '0;
    set_tables();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_degenerate", 64'(bus.degenerate), 64'd0);
    chk("rst_belief_out", 64'(bus.belief_out), 64'd0);

    drive_req(mkv(16'h8000, 16'h8000), 0, 0, nom, 1'b0, LAT_NOM);
    @(negedge clk);
    chk("busy_inflight", 64'(bus.busy), 64'd1);
    chk("in_ready_inflight", 64'(bus.in_ready), 64'd0);
    wait_drain();

    drive_req(mkv(16'h4000, 16'hC000), 1, 1, mkv(16'h4000, 16'hC000), 1'b0, LAT_NOM);
    wait_drain();
    drive_req(mkv(16'hFFFF, 16'h0000), 2, 1, mkv(16'hFFFF, 16'h0000), 1'b0, LAT_NOM);
    wait_drain();
    drive_req(mkv(16'h1234, 16'hEDCC), 1, 0, mkv(16'h1234, 16'hEDCC), 1'b1, LAT_DEN);
    wait_drain();
    drive_req(mkv(16'hABCD, 16'h0123), 3, 0, mkv(16'hABCD, 16'h0123), 1'b1, LAT_BAD);
    wait_drain();

    // Backpressure: result must sit frozen while inputs churn.
    bus.out_ready = 1'b0;
    drive_req(mkv(16'h8000, 16'h8000), 0, 0, nom, 1'b0, LAT_NOM);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = k[0];
      bus.belief_in = mkv(16'($urandom), 16'($urandom));
      bus.action    = 2'($urandom_range(0, 2));
      @(negedge clk);
      chk("bp_belief_frozen", 64'(bus.belief_out), 64'(nom));
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    chk("bp_queue_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("bp_no_second_accept", 64'(bus.busy), 64'd0);

    // Reset in the middle of DIVIDE discards the in-flight result.
    drive_req(mkv(16'h8000, 16'h8000), 0, 0, nom, 1'b0, LAT_NOM);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_belief_out", 64'(bus.belief_out), 64'd0);
    rst = 1'b0;
    drive_req(mkv(16'h8000, 16'h8000), 0, 0, nom, 1'b0, LAT_NOM);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
